// File: rtl/store_drain_buffer_if.sv
// Bundle of store-lane capture, ROB completion/commit and memory write signals.
// The buffer connects through the slave modport; its environment uses master.
interface store_drain_buffer_if #(
  parameter int WORD_SIZE  = 32,
  parameter int RB_INDEX   = 4,
  parameter int STORER_NUM = 2
);
  logic [STORER_NUM-1:0]           st_valid;
  logic [STORER_NUM*WORD_SIZE-1:0] st_addr;
  logic [STORER_NUM*WORD_SIZE-1:0] st_data;
  logic [STORER_NUM*RB_INDEX-1:0]  st_rb;
  logic                            full;
  logic                            empty;
  logic [STORER_NUM-1:0]           done_valid;
  logic [STORER_NUM*RB_INDEX-1:0]  done_rb;
  logic                            commit_valid;
  logic [RB_INDEX-1:0]             commit_rb;
  logic                            flush;
  logic                            mem_req;
  logic [WORD_SIZE-1:0]            mem_addr;
  logic [WORD_SIZE-1:0]            mem_wdata;
  logic                            mem_ack;
  logic [1:0]                      err;

  modport master (
    output st_valid, st_addr, st_data, st_rb, commit_valid, commit_rb, flush, mem_ack,
    input  full, empty, done_valid, done_rb, mem_req, mem_addr, mem_wdata, err
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_rb, commit_valid, commit_rb, flush, mem_ack,
    output full, empty, done_valid, done_rb, mem_req, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/store_drain_buffer.sv
// Holds completed stores until the ROB commits them, then writes them to memory
// in commit order over a req/ack port; uncommitted stores are dropped on flush.
module store_drain_buffer #(
  parameter int WORD_SIZE  = 32,
  parameter int RB_INDEX   = 4,
  parameter int STORER_NUM = 2,
  parameter int DEPTH      = 4,
  parameter int ENT_INDEX  = 2
) (
  input logic                clk,
  input logic                reset,
  store_drain_buffer_if.slave bus
);
  typedef enum logic [1:0] {ENT_FREE, ENT_PENDING, ENT_COMMITTED} ent_state_t;
  typedef enum logic {DRAIN_IDLE, DRAIN_REQ} drain_state_t;

  ent_state_t             ent_state_reg  [DEPTH];
  ent_state_t             ent_state_next [DEPTH];
  logic [WORD_SIZE-1:0]   ent_addr       [DEPTH];
  logic [WORD_SIZE-1:0]   ent_data       [DEPTH];
  logic [RB_INDEX-1:0]    ent_rb         [DEPTH];
  logic [ENT_INDEX-1:0]   order_fifo     [DEPTH];
  logic [ENT_INDEX-1:0]   head_reg, tail_reg;
  logic [ENT_INDEX:0]     count_reg;
  drain_state_t           drain_state_reg;

  logic [WORD_SIZE-1:0]   lane_addr [STORER_NUM];
  logic [WORD_SIZE-1:0]   lane_data [STORER_NUM];
  logic [RB_INDEX-1:0]    lane_rb   [STORER_NUM];

  logic                   commit_hit;
  logic [ENT_INDEX-1:0]   commit_idx;
  logic [STORER_NUM-1:0]  lane_ok, lane_drop, lane_cap;
  logic [ENT_INDEX-1:0]   alloc_idx [STORER_NUM];
  logic                   drain_pop;
  logic [ENT_INDEX:0]     free_next;
  logic                   any_live_next;

  logic                   full_reg, empty_reg, mem_req_reg;
  logic [STORER_NUM-1:0]  done_valid_reg;
  logic [STORER_NUM*RB_INDEX-1:0] done_rb_reg;
  logic [WORD_SIZE-1:0]   mem_addr_reg, mem_wdata_reg;
  logic [1:0]             err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STORER_NUM; gi++) begin : g_lane
      assign lane_addr[gi] = bus.st_addr[gi*WORD_SIZE +: WORD_SIZE];
      assign lane_data[gi] = bus.st_data[gi*WORD_SIZE +: WORD_SIZE];
      assign lane_rb[gi]   = bus.st_rb[gi*RB_INDEX +: RB_INDEX];
    end
  endgenerate

  assign drain_pop = (drain_state_reg == DRAIN_REQ) && bus.mem_ack;

  always_comb begin
    logic [DEPTH-1:0] taken;
    logic             found;
    logic             dup;
    commit_hit = 1'b0;
    commit_idx = '0;
    lane_ok    = '0;
    lane_drop  = '0;
    taken      = '0;
    found      = 1'b0;
    dup        = 1'b0;
    for (int ln = 0; ln < STORER_NUM; ln++) alloc_idx[ln] = '0;

    // All lookups see pre-edge state: same-edge captures and frees are invisible.
    for (int e = 0; e < DEPTH; e++) begin
      taken[e] = (ent_state_reg[e] != ENT_FREE);
      if (bus.commit_valid && !commit_hit && ent_state_reg[e] == ENT_PENDING &&
          ent_rb[e] == bus.commit_rb) begin
        commit_hit = 1'b1;
        commit_idx = ENT_INDEX'(e);
      end
    end

    for (int ln = 0; ln < STORER_NUM; ln++) begin
      found = 1'b0;
      dup   = 1'b0;
      for (int e = 0; e < DEPTH; e++)
        if (ent_state_reg[e] != ENT_FREE && ent_rb[e] == lane_rb[ln]) dup = 1'b1;
      for (int k = 0; k < ln; k++)
        if (lane_ok[k] && lane_rb[k] == lane_rb[ln]) dup = 1'b1;
      for (int e = 0; e < DEPTH; e++)
        if (!found && !taken[e]) begin
          found = 1'b1;
          alloc_idx[ln] = ENT_INDEX'(e);
        end
      if (bus.st_valid[ln]) begin
        if (found && !dup) begin
          lane_ok[ln] = 1'b1;
          taken[alloc_idx[ln]] = 1'b1;
        end else begin
          lane_drop[ln] = 1'b1;
        end
      end
    end
    lane_cap = lane_ok & {STORER_NUM{~bus.flush}};

    for (int e = 0; e < DEPTH; e++) ent_state_next[e] = ent_state_reg[e];
    if (commit_hit) ent_state_next[commit_idx] = ENT_COMMITTED;
    if (bus.flush)
      for (int e = 0; e < DEPTH; e++)
        if (ent_state_next[e] == ENT_PENDING) ent_state_next[e] = ENT_FREE;
    for (int ln = 0; ln < STORER_NUM; ln++)
      if (lane_cap[ln]) ent_state_next[alloc_idx[ln]] = ENT_PENDING;
    if (drain_pop) ent_state_next[order_fifo[head_reg]] = ENT_FREE;

    free_next     = '0;
    any_live_next = 1'b0;
    for (int e = 0; e < DEPTH; e++)
      if (ent_state_next[e] == ENT_FREE) free_next = free_next + 1'b1;
      else any_live_next = 1'b1;
  end

  // Payload storage needs no reset: it is only read while its entry is live.
  always_ff @(posedge clk) begin
    for (int ln = 0; ln < STORER_NUM; ln++)
      if (lane_cap[ln]) begin
        ent_addr[alloc_idx[ln]] <= lane_addr[ln];
        ent_data[alloc_idx[ln]] <= lane_data[ln];
        ent_rb[alloc_idx[ln]]   <= lane_rb[ln];
      end
    if (commit_hit) order_fifo[tail_reg] <= commit_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) ent_state_reg[e] <= ENT_FREE;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      done_valid_reg <= '0;
      done_rb_reg    <= '0;
      err_reg        <= '0;
      full_reg       <= 1'b0;
      empty_reg      <= 1'b1;
    end else begin
      ent_state_reg <= ent_state_next;
      if (commit_hit) tail_reg <= tail_reg + 1'b1;
      if (drain_pop)  head_reg <= head_reg + 1'b1;
      case ({commit_hit, drain_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      done_valid_reg <= lane_cap;
      for (int ln = 0; ln < STORER_NUM; ln++)
        if (lane_cap[ln]) done_rb_reg[ln*RB_INDEX +: RB_INDEX] <= lane_rb[ln];
      err_reg   <= err_reg | {bus.commit_valid & ~commit_hit, |lane_drop};
      full_reg  <= (free_next < (ENT_INDEX+1)'(STORER_NUM));
      empty_reg <= ~any_live_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_state_reg <= DRAIN_IDLE;
      mem_req_reg     <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
    end else begin
      case (drain_state_reg)
        DRAIN_IDLE:
          if (count_reg != '0) begin
            mem_addr_reg    <= ent_addr[order_fifo[head_reg]];
            mem_wdata_reg   <= ent_data[order_fifo[head_reg]];
            mem_req_reg     <= 1'b1;
            drain_state_reg <= DRAIN_REQ;
          end
        DRAIN_REQ:
          if (bus.mem_ack) begin
            mem_req_reg     <= 1'b0;
            drain_state_reg <= DRAIN_IDLE;
          end
        default: drain_state_reg <= DRAIN_IDLE;
      endcase
    end
  end

  assign bus.full       = full_reg;
  assign bus.empty      = empty_reg;
  assign bus.done_valid = done_valid_reg;
  assign bus.done_rb    = done_rb_reg;
  assign bus.mem_req    = mem_req_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;
  assign bus.err        = err_reg;
endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed scenarios plus randomized traffic, every cycle compared against a
// queue-based model of live stores and the commit-ordered write stream.
module tb_store_drain_buffer;
  localparam int W     = 32;
  localparam int RB    = 4;
  localparam int SN    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  store_drain_buffer_if #(.WORD_SIZE(W), .RB_INDEX(RB), .STORER_NUM(SN)) bus ();

  store_drain_buffer #(
    .WORD_SIZE(W), .RB_INDEX(RB), .STORER_NUM(SN), .DEPTH(DEPTH), .ENT_INDEX(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] addr;
    logic [31:0] data;
    bit          committed;
  } rec_t;

  rec_t        live[$];
  rec_t        wq[$];
  bit          m_busy;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_dv;
  logic [3:0]  m_drb [SN];
  logic [1:0]  m_err;
  int          n_writes = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    live.delete();
    wq.delete();
    m_busy  = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_dv    = '0;
    m_err   = '0;
    for (int i = 0; i < SN; i++) m_drb[i] = '0;
  endfunction

  // One clock edge of the buffer's rules, evaluated on pre-edge contents.
  function automatic void model_step();
    int          nfree;
    rec_t        fresh[$];
    logic [3:0]  t;
    bit          dup, hit;
    nfree = DEPTH - live.size();
    m_dv  = '0;
    for (int ln = 0; ln < SN; ln++) begin
      if (bus.st_valid[ln]) begin
        t   = bus.st_rb[ln*RB +: RB];
        dup = 1'b0;
        foreach (live[k]) if (live[k].tag == t) dup = 1'b1;
        if (dup || nfree == 0) m_err[0] = 1'b1;
        else begin
          nfree--;
          if (!bus.flush) begin
            rec_t r;
            r.tag       = t;
            r.addr      = bus.st_addr[ln*W +: W];
            r.data      = bus.st_data[ln*W +: W];
            r.committed = 1'b0;
            fresh.push_back(r);
            m_dv[ln]  = 1'b1;
            m_drb[ln] = t;
          end
        end
      end
    end
    if (m_busy && bus.mem_ack) begin
      $display("write %0d: addr=%08h data=%08h tag=%0d", n_writes, wq[0].addr, wq[0].data, wq[0].tag);
      for (int k = 0; k < live.size(); k++)
        if (live[k].tag == wq[0].tag) begin
          live.delete(k);
          break;
        end
      void'(wq.pop_front());
      m_busy = 1'b0;
      n_writes++;
    end else if (!m_busy && wq.size() > 0) begin
      m_busy  = 1'b1;
      m_addr  = wq[0].addr;
      m_wdata = wq[0].data;
    end
    if (bus.commit_valid) begin
      hit = 1'b0;
      for (int k = 0; k < live.size(); k++)
        if (!hit && !live[k].committed && live[k].tag == bus.commit_rb) begin
          live[k].committed = 1'b1;
          wq.push_back(live[k]);
          hit = 1'b1;
        end
      if (!hit) m_err[1] = 1'b1;
    end
    if (bus.flush)
      for (int k = live.size() - 1; k >= 0; k--)
        if (!live[k].committed) live.delete(k);
    foreach (fresh[k]) live.push_back(fresh[k]);
  endfunction

  task automatic check_outputs(input string pfx);
    check_value({pfx, "_done_valid"}, bus.done_valid, m_dv);
    check_value({pfx, "_done_rb0"}, bus.done_rb[3:0], m_drb[0]);
    check_value({pfx, "_done_rb1"}, bus.done_rb[7:4], m_drb[1]);
    check_value({pfx, "_full"}, bus.full, (DEPTH - live.size()) < SN);
    check_value({pfx, "_empty"}, bus.empty, live.size() == 0);
    check_value({pfx, "_err"}, bus.err, m_err);
    check_value({pfx, "_mem_req"}, bus.mem_req, m_busy);
    check_value({pfx, "_mem_addr"}, bus.mem_addr, m_addr);
    check_value({pfx, "_mem_wdata"}, bus.mem_wdata, m_wdata);
  endtask

  task automatic set_idle();
    bus.st_valid     = '0;
    bus.st_addr      = '0;
    bus.st_data      = '0;
    bus.st_rb        = '0;
    bus.commit_valid = 1'b0;
    bus.commit_rb    = '0;
    bus.flush        = 1'b0;
    bus.mem_ack      = 1'b0;
  endtask

  // Called at a falling edge; asserts reset between edges to see it act at once.
  task automatic do_reset(input string pfx);
    set_idle();
    #2 reset = 1'b1;
    model_reset();
    #1 check_outputs(pfx);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_cycle(input logic [1:0] v,
                           input logic [3:0] r0, input logic [31:0] a0, input logic [31:0] d0,
                           input logic [3:0] r1, input logic [31:0] a1, input logic [31:0] d1,
                           input logic cv, input logic [3:0] crb, input logic fl, input logic ack,
                           input string pfx);
    bus.st_valid     = v;
    bus.st_rb        = {r1, r0};
    bus.st_addr      = {a1, a0};
    bus.st_data      = {d1, d0};
    bus.commit_valid = cv;
    bus.commit_rb    = crb;
    bus.flush        = fl;
    bus.mem_ack      = ack;
    @(posedge clk);
    model_step();
    #1 check_outputs(pfx);
    @(negedge clk);
  endtask

  task automatic idle_cycle(input logic ack, input string pfx);
    run_cycle(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, ack, pfx);
  endtask

  task automatic commit_cycle(input logic [3:0] crb, input logic fl, input logic ack, input string pfx);
    run_cycle(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 1'b1, crb, fl, ack, pfx);
  endtask

  logic [1:0]  rv;
  logic [3:0]  rr0, rr1, rcrb;
  logic        rcv, rfl, rack;
  logic [3:0]  pend[$];

  initial begin
    set_idle();
    @(negedge clk);

    // Single store end to end.
    do_reset("rst");
    run_cycle(2'b01, 4'd3, 32'h100, 32'hDEADBEEF, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, "t1_cap");
    check_value("t1_done", {bus.done_valid, bus.done_rb[3:0]}, {2'b01, 4'd3});
    commit_cycle(4'd3, 1'b0, 1'b0, "t1_commit");
    idle_cycle(1'b0, "t1_req");
    check_value("t1_req_addr", {bus.mem_req, bus.mem_addr, bus.mem_wdata}, {1'b1, 32'h100, 32'hDEADBEEF});
    idle_cycle(1'b1, "t1_ack");
    check_value("t1_empty", bus.empty, 1'b1);

    // Two lanes at once, committed in reverse order.
    run_cycle(2'b11, 4'd5, 32'h200, 32'h55, 4'd6, 32'h300, 32'h66, 1'b0, 4'd0, 1'b0, 1'b0, "t2_cap");
    check_value("t2_done", {bus.done_valid, bus.done_rb}, {2'b11, 4'd6, 4'd5});
    commit_cycle(4'd6, 1'b0, 1'b0, "t2_c6");
    commit_cycle(4'd5, 1'b0, 1'b0, "t2_c5");
    check_value("t2_first_addr", bus.mem_addr, 32'h300);
    idle_cycle(1'b1, "t2_ack6");
    idle_cycle(1'b0, "t2_req5");
    check_value("t2_second_addr", bus.mem_addr, 32'h200);
    idle_cycle(1'b1, "t2_ack5");

    // Fill to capacity, then overflow.
    do_reset("t3_rst");
    run_cycle(2'b11, 4'd1, 32'h10, 32'h1, 4'd2, 32'h20, 32'h2, 1'b0, 4'd0, 1'b0, 1'b0, "t3_a");
    run_cycle(2'b11, 4'd3, 32'h30, 32'h3, 4'd4, 32'h40, 32'h4, 1'b0, 4'd0, 1'b0, 1'b0, "t3_b");
    check_value("t3_full", bus.full, 1'b1);
    run_cycle(2'b01, 4'd10, 32'h50, 32'h5, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, "t3_drop");
    check_value("t3_drop_err", {bus.err, bus.done_valid}, {2'b01, 2'b00});

    // Commit and flush on the same edge.
    do_reset("t4_rst");
    run_cycle(2'b11, 4'd7, 32'h700, 32'h77, 4'd8, 32'h800, 32'h88, 1'b0, 4'd0, 1'b0, 1'b0, "t4_cap");
    commit_cycle(4'd7, 1'b1, 1'b0, "t4_cflush");
    idle_cycle(1'b0, "t4_req");
    check_value("t4_addr", bus.mem_addr, 32'h700);
    idle_cycle(1'b1, "t4_ack");
    check_value("t4_empty", bus.empty, 1'b1);

    // Commit of a tag that was never captured.
    commit_cycle(4'd9, 1'b0, 1'b0, "t5_miss");
    idle_cycle(1'b0, "t5_idle");
    check_value("t5_err_req", {bus.err, bus.mem_req}, {2'b10, 1'b0});

    // Stall in REQ, then reset mid-write.
    do_reset("t6_rst");
    run_cycle(2'b10, 4'd0, 32'd0, 32'd0, 4'd11, 32'hB00, 32'hBB, 1'b0, 4'd0, 1'b0, 1'b0, "t6_cap");
    commit_cycle(4'd11, 1'b0, 1'b0, "t6_commit");
    for (int i = 0; i < 6; i++) idle_cycle(1'b0, "t6_stall");
    check_value("t6_held", {bus.mem_req, bus.mem_addr}, {1'b1, 32'hB00});
    do_reset("t6_midwrite");

    // Randomized traffic, rising flush rate and ack rate per block.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset("rnd_rst");
      for (int c = 0; c < 150; c++) begin
        rv[0] = ($urandom % 100) < 35;
        rv[1] = ($urandom % 100) < 35;
        rr0   = 4'($urandom % 16);
        rr1   = 4'($urandom % 16);
        if (rr1 == rr0) rr1 = rr0 + 4'd1;
        rcv   = ($urandom % 100) < 45;
        pend.delete();
        foreach (live[k]) if (!live[k].committed) pend.push_back(live[k].tag);
        if (pend.size() > 0 && ($urandom % 10) != 0) rcrb = pend[$urandom % pend.size()];
        else rcrb = 4'($urandom % 16);
        rfl   = ($urandom % 100) < (blk * 3);
        rack  = ($urandom % 100) < (30 + blk * 20);
        run_cycle(rv, rr0, $urandom, $urandom, rr1, $urandom, $urandom, rcv, rcrb, rfl, rack, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/store_drain_buffer.md
Name: store_drain_buffer

Overview:
Receiving end of the store reservation stations' output buses. Each cycle it captures address, data and RB index from every storer lane whose valid is high, and reports completion to the reorder buffer. Entries are held until the ROB commits their RB index, then written to data memory in commit order over a req/ack port. Squashed (uncommitted) stores are discarded on flush.

Parameters:
WORD_SIZE, 32, data/address width
RB_INDEX, 4, RB tag width
STORER_NUM, 2, number of store RS lanes
DEPTH, 4, buffer entries (power of 2, >= STORER_NUM)
ENT_INDEX, 2, log2(DEPTH)

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
st_valid  in  STORER_NUM  per-lane store-ready pulse from store RS
st_addr  in  STORER_NUM*WORD_SIZE  lane i at [(i+1)*WORD_SIZE-1 : i*WORD_SIZE]
st_data  in  STORER_NUM*WORD_SIZE  store data, same packing
st_rb  in  STORER_NUM*RB_INDEX  RB tag per lane
full  out  1  fewer than STORER_NUM free entries; RS must not complete
empty  out  1  all entries FREE
done_valid  out  STORER_NUM  per-lane capture acknowledge to ROB
done_rb  out  STORER_NUM*RB_INDEX  tag of acknowledged store
commit_valid  in  1  ROB commits a store this cycle
commit_rb  in  RB_INDEX  tag being committed
flush  in  1  discard all uncommitted entries
mem_req  out  1  memory write request
mem_addr  out  WORD_SIZE  write address
mem_wdata  out  WORD_SIZE  write data
mem_ack  in  1  memory accepted the write
err  out  2  sticky: [0] capture dropped/duplicate tag, [1] commit miss

Behaviour:
- Reset (async): all entries FREE, order FIFO empty, drain FSM IDLE; mem_req=0, mem_addr=0, mem_wdata=0, done_valid=0, done_rb=0, err=0, full=0, empty=1. Reset mid-write drops mem_req immediately; the pending write is lost.
- Entry states: FREE -> PENDING (captured) -> COMMITTED (queued) -> FREE (written).
- Capture: at posedge, each lane with st_valid=1 is allocated the lowest-index FREE entry, lane 0 first. Store addr, data, tag. Entries freed on the same edge are not reused until the next cycle.
- Lane with no FREE entry, or tag equal to an existing PENDING/COMMITTED entry: dropped, err[0] set.
- done_valid[i]/done_rb[i] pulse high for exactly one cycle, the cycle after a successful capture of lane i. done_rb holds its last value when done_valid=0.
- full/empty: registered, reflecting state after the current edge.
- Commit: at posedge with commit_valid=1, the PENDING entry with tag commit_rb becomes COMMITTED, and its index is pushed into the order FIFO (DEPTH deep).
- No matching PENDING entry: err[1] set, no other effect.
- Same-edge capture of that tag is not visible to the commit, so it is a miss.
- Flush: at posedge, all PENDING entries become FREE; COMMITTED entries and the order FIFO are untouched.
  - flush+commit same edge: commit applied first, so the committed entry survives.
  - flush+capture same edge: captured entries are discarded and no done pulse is issued.
- Drain FSM:
  - IDLE: if order FIFO non-empty, load mem_addr/mem_wdata from the head entry, set mem_req=1, go to REQ.
  - REQ: hold mem_req and mem_addr/mem_wdata stable until mem_ack is sampled 1. Then mem_req=0, free the head entry, pop the FIFO, go to IDLE.
  - mem_ack while IDLE is ignored.
- Latency: commit at edge N -> mem_req high after edge N+1 (if FSM idle). Minimum 2 cycles per write (ack in first REQ cycle).
- Writes always issue in commit order, never capture order.

Test Plan:
- Reset, then lane0 st_valid, addr 0x100, data 0xDEADBEEF, rb 3 -> done_valid[0]=1, done_rb=3 next cycle. commit_rb=3 -> mem_req after 1 edge with 0x100/0xDEADBEEF. mem_ack -> entry freed, empty=1.
- Both lanes same cycle, rb 5 (lane0) and rb 6 (lane1); commit 6 then 5 -> memory sees rb6's write before rb5's; both done pulses in the same cycle.
- Fill DEPTH=4 with rb 1..4 -> full=1 once free<2. Fifth capture dropped, err[0]=1, no done pulse.
- Capture rb 7 and rb 8; commit 7 with flush on the same edge -> rb7 written to memory, rb8 discarded, empty=1 after drain.
- Commit rb 9 never captured -> err[1]=1, mem_req stays 0.
- Hold mem_ack=0 for 5 cycles in REQ, then assert reset -> mem_req stays stable for those cycles, then drops to 0 asynchronously, all outputs at reset values.
